// File: rtl/mem_stream_loader_if.sv
// Byte-stream input and 32-bit RAM write port of the stream loader.
// The master modport is the loader side; the slave modport is the stream source and RAM side.
interface mem_stream_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );
endinterface

// File: rtl/mem_stream_loader.sv
// Packs an 8-bit valid/ready stream little-endian into 32-bit words and writes them
// to on-chip RAM from a commanded word address, with range check, abort and done status.
module mem_stream_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 6500,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              abort,
  mem_stream_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WW = ADDR_W + CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        lane;
  logic [31:0]       lane_data;

  logic [WW-1:0]     words_w;
  logic [WW-1:0]     end_w;
  logic              range_err;
  logic              accept;
  logic              last_byte;
  logic              word_done;
  logic [31:0]       packed_word;

  function automatic logic [3:0] lane_mask(input logic [1:0] l);
    return {l == 2'd3, l >= 2'd2, l != 2'd0, 1'b1};
  endfunction

  function automatic logic [31:0] pack_byte(input logic [31:0] acc, input logic [7:0] b,
                                            input logic [1:0] l);
    return acc | (32'(b) << {l, 3'b000});
  endfunction

  // Range check is done wide enough that start_addr + words can never wrap.
  assign words_w   = (WW'(byte_count) + WW'(3)) >> 2;
  assign end_w     = WW'(start_addr) + words_w;
  assign range_err = (WW'(start_addr) >= WW'(DEPTH)) || (end_w > WW'(DEPTH));

  assign accept      = (state == RUN) && bus.in_valid && bus.in_ready && !abort;
  assign last_byte   = accept && (remaining == CNT_W'(1));
  assign word_done   = accept && ((lane == 2'd3) || (remaining == CNT_W'(1)));
  assign packed_word = pack_byte(lane_data, bus.in_data, lane);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !range_err && (byte_count != '0)) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (last_byte) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt           <= '0;
      remaining          <= '0;
      lane               <= '0;
      lane_data          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      bus.in_ready       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_byteenable <= '0;
      bus.mem_writedata  <= '0;
    end else begin
      busy               <= (state_nxt != IDLE);
      bus.in_ready       <= (state_nxt == RUN);
      done               <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_chipselect <= 1'b0;

      if ((state == IDLE) && start) begin
        addr_cnt  <= start_addr;
        remaining <= byte_count;
        lane      <= '0;
        lane_data <= '0;
        error     <= range_err;
        if (range_err || (byte_count == '0)) done <= 1'b1;
      end

      // The final write is on the bus during FLUSH; an abort here still suppresses done.
      if ((state == FLUSH) && !abort) done <= 1'b1;

      if (accept) begin
        remaining <= remaining - CNT_W'(1);
        if (word_done) begin
          bus.mem_write      <= 1'b1;
          bus.mem_chipselect <= 1'b1;
          bus.mem_address    <= addr_cnt;
          bus.mem_writedata  <= packed_word;
          bus.mem_byteenable <= lane_mask(lane);
          addr_cnt           <= addr_cnt + ADDR_W'(1);
          lane               <= '0;
          lane_data          <= '0;
        end else begin
          lane_data <= packed_word;
          lane      <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed and randomized bench for mem_stream_loader against a word-chunking reference model.
module tb_mem_stream_loader;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 6500;
  localparam int CNT_W  = 16;

  typedef struct packed {
    int          c;
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  byte_count = '0;
  logic              busy, done, error;

  mem_stream_loader_if #(.ADDR_W(ADDR_W)) bus();

  mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .byte_count (byte_count),
    .abort      (abort),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  wr_t wq[$];
  wr_t eq[$];
  int  dq[$];

  always @(negedge clk) begin
    wr_t w;
    if (reset_n) chk("cs_eq_write", bus.mem_chipselect, bus.mem_write);
    if (bus.mem_write) begin
      w.c = cyc; w.a = bus.mem_address; w.d = bus.mem_writedata; w.be = bus.mem_byteenable;
      wq.push_back(w);
    end
    if (done) dq.push_back(cyc);
  end

  // Reference: split the byte list into 4-byte chunks, little-endian, enables = filled lanes.
  function automatic void model(input int addr, input logic [7:0] b[$]);
    wr_t w;
    eq.delete();
    for (int i = 0; i * 4 < b.size(); i++) begin
      int n = (b.size() - i * 4 >= 4) ? 4 : b.size() - i * 4;
      w.c = 0; w.a = 13'(addr + i); w.d = 0;
      for (int k = 0; k < n; k++) w.d = w.d | (32'(b[i * 4 + k]) << (8 * k));
      w.be = 4'((1 << n) - 1);
      eq.push_back(w);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int addr, input int cnt, output int t0);
    wq.delete(); dq.delete();
    start = 1'b1; start_addr = ADDR_W'(addr); byte_count = CNT_W'(cnt);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b[$], input int gap_max);
    int i = 0;
    int budget = 0;
    while (i < b.size() && budget < 500) begin
      if (gap_max > 0 && $urandom_range(0, gap_max) == 0) bus.in_valid = 1'b0;
      else begin bus.in_valid = 1'b1; bus.in_data = b[i]; end
      if (bus.in_valid && bus.in_ready) i++;
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    chk("feed_consumed", i, b.size());
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, wq.size(), eq.size());
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      chk({tag, "_addr"}, wq[i].a, eq[i].a);
      chk({tag, "_data"}, wq[i].d, eq[i].d);
      chk({tag, "_be"},   wq[i].be, eq[i].be);
    end
  endtask

  task automatic run_cmd(input string tag, input int addr, input int cnt, input int gap);
    logic [7:0] b[$];
    int t0;
    for (int i = 0; i < cnt; i++) b.push_back(8'($urandom));
    issue(addr, cnt, t0);
    feed(b, gap);
    cycles(4);
    model(addr, b);
    check_writes(tag);
    chk({tag, "_done_cnt"}, dq.size(), 1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    logic [7:0] b[$];
    int t0;
    int extra;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_write", bus.mem_write, 1'b0);
    chk("rst_cs", bus.mem_chipselect, 1'b0);
    chk("rst_be", bus.mem_byteenable, 4'h0);
    chk("rst_addr", bus.mem_address, 13'h0);
    chk("rst_data", bus.mem_writedata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(2);

    // Eight bytes back-to-back with cycle-exact timing
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    issue(32'h10, 8, t0);
    chk("t1_busy_c1", busy, 1'b1);
    chk("t1_ready_c1", bus.in_ready, 1'b1);
    feed(b, 0);
    cycles(4);
    model(32'h10, b);
    check_writes("t1");
    if (wq.size() == 2) begin
      chk("t1_w0_cycle", wq[0].c - t0, 5);
      chk("t1_w1_cycle", wq[1].c - t0, 9);
    end
    chk("t1_done_cnt", dq.size(), 1);
    if (dq.size() > 0) chk("t1_done_cycle", dq[0] - t0, 10);

    // Six bytes with random gaps, final partial word
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    issue(32'h123, 6, t0);
    feed(b, 2);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h55;
      if (bus.in_ready) extra++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t2_extra_bytes", extra, 0);
    cycles(2);
    model(32'h123, b);
    check_writes("t2");
    chk("t2_done_cnt", dq.size(), 1);

    // Zero count
    issue(32'h40, 0, t0);
    chk("zero_done_c1", done, 1'b1);
    chk("zero_busy_c1", busy, 1'b0);
    chk("zero_error", error, 1'b0);
    cycles(3);
    chk("zero_nwrites", wq.size(), 0);

    // Range error: 6499 + 2 words > 6500
    issue(6499, 5, t0);
    chk("err_done_c1", done, 1'b1);
    chk("err_error_c1", error, 1'b1);
    chk("err_busy_c1", busy, 1'b0);
    chk("err_ready_c1", bus.in_ready, 1'b0);
    cycles(3);
    chk("err_nwrites", wq.size(), 0);
    chk("err_done_cnt", dq.size(), 1);
    chk("err_sticky", error, 1'b1);

    // Exactly reaching the top word is legal and clears the error
    run_cmd("top_ok", 6499, 4, 1);

    // Start address at DEPTH is out of range even for one byte
    issue(6500, 1, t0);
    chk("oob_error_c1", error, 1'b1);
    cycles(3);
    chk("oob_nwrites", wq.size(), 0);
    run_cmd("after_err", 7, 3, 0);

    // Abort after two bytes of the third word
    b.delete();
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
    issue(32'h200, 12, t0);
    feed(b, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", bus.in_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    cycles(4);
    b = b[0:7];
    model(32'h200, b);
    check_writes("abort");
    chk("abort_no_done", dq.size(), 0);
    run_cmd("post_abort", 32'h300, 9, 1);

    // Start while busy must not relatch the address
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    issue(32'h50, 8, t0);
    feed(b[0:1], 0);
    start = 1'b1; start_addr = 13'h999; byte_count = 16'd3;
    @(negedge clk);
    start = 1'b0;
    feed(b[2:7], 0);
    cycles(4);
    model(32'h50, b);
    check_writes("busy_start");
    chk("busy_start_done", dq.size(), 1);

    // Asynchronous reset mid-command
    b.delete();
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    issue(32'h80, 8, t0);
    feed(b, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_write", bus.mem_write, 1'b0);
    chk("arst_addr", bus.mem_address, 13'h0);
    chk("arst_data", bus.mem_writedata, 32'h0);
    chk("arst_be", bus.mem_byteenable, 4'h0);
    @(negedge clk);
    wq.delete(); dq.delete();
    reset_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    cycles(6);
    bus.in_valid = 1'b0;
    chk("arst_no_writes", wq.size(), 0);
    chk("arst_no_done", dq.size(), 0);
    chk("arst_idle_ready", bus.in_ready, 1'b0);

    // Randomized commands
    for (int r = 0; r < 6; r++) begin
      int cnt  = $urandom_range(1, 17);
      int addr = $urandom_range(0, DEPTH - (cnt + 3) / 4);
      run_cmd("rand", addr, cnt, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_stream_loader.md
# mem_stream_loader

Byte-stream-to-memory loader sitting directly upstream of the 32-bit single-port on-chip RAM (6500 words, 13-bit word address, byte enables). It accepts an 8-bit valid/ready stream, packs bytes little-endian into 32-bit words and issues single-cycle writes on the RAM's slave port (address, byteenable, chipselect, write, writedata). It is used to fill program/data images into on-chip memory at a commanded word address, with range checking, abort and completion status.

## Interface
- ADDR_W, 13, RAM word-address width
- DEPTH, 6500, RAM depth in 32-bit words; writes at or beyond DEPTH are never issued
- CNT_W, 16, width of byte_count
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- start_addr  in  ADDR_W  first word address, sampled with start
- byte_count  in  CNT_W  number of bytes to load, sampled with start
- abort  in  1  synchronous cancel; discards partial word
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte when in_valid & in_ready
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  lane enables, bit k = writedata[8k+7:8k]
- mem_chipselect  out  1  equal to mem_write
- mem_write  out  1  one-cycle write strobe
- mem_writedata  out  32  packed word
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky range error; cleared by next accepted start

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: in_ready=0. On start: latch start_addr into address counter, byte_count into remaining counter, clear error, clear lane counter.
  - words = (byte_count+3)>>2 computed at ADDR_W+CNT_W+1 bits; if start_addr >= DEPTH or start_addr+words > DEPTH: set error, pulse done next cycle, stay IDLE, no write.
  - byte_count == 0: pulse done next cycle, stay IDLE, no write, error=0.
  - otherwise -> RUN.
- RUN: in_ready=1. Each accepted byte goes to lane = lane counter (0..3), lane counter increments mod 4, remaining decrements.
  - Word emitted when lane 3 filled or last byte accepted; byteenable = lanes filled (4'hF, or 4'h1/3/7 for final partial word); unfilled lanes of writedata are 0.
  - After emit, address counter increments; lane register cleared while continuing to accept the next byte in the same cycle (1 byte/cycle sustained).
  - Last byte accepted -> FLUSH; in_ready=0 from the following cycle.
- FLUSH: final write is on the bus this cycle -> IDLE, done pulse next cycle.
- abort (any non-IDLE state): -> IDLE next cycle, in_ready=0, partial word discarded, a write already registered still completes, no done, error unchanged. abort in IDLE ignored.
- start while not IDLE ignored. start and abort together in IDLE: abort ignored, start honoured.
- in_valid while in_ready=0: byte not consumed, no effect.

## Timing
- Reset values: in_ready=0, mem_write=0, mem_chipselect=0, mem_byteenable=0, mem_address=0, mem_writedata=0, busy=0, done=0, error=0, state IDLE, counters 0. Reset mid-command abandons it with no further writes.
- All outputs registered.
- start at cycle 0 -> busy=1 and in_ready=1 from cycle 1.
- Byte completing a word accepted at cycle t -> mem_write=1 for exactly cycle t+1 with final address/data/byteenable.
- Last byte at cycle L -> final write cycle L+1 (FLUSH), busy=0 and done=1 at cycle L+2.
- Zero-count or error command: done=1 at cycle 1, busy stays 0, error (if any) valid at cycle 1.
- RAM has no wait-state; every mem_write cycle is a completed write. Max write rate: one every 4 cycles during full-word streaming.

## Test plan
- start_addr=0x010, count=8, bytes 01..08 back-to-back -> writes (0x010, 0x04030201, F) at cycle 5, (0x011, 0x08070605, F) at cycle 9; done at cycle 10.
- count=6, bytes AA BB CC DD EE FF with random in_valid gaps -> (addr, 0xDDCCBBAA, F), (addr+1, 0x0000FFEE, 3); exactly 6 bytes consumed.
- count=0 -> done at cycle 1, no mem_write, error=0; start_addr=6499, count=5 -> error=1, done pulse, no mem_write; next valid start clears error.
- abort after 2 bytes of 3rd word (count=12) -> two full writes only, no done, in_ready=0 next cycle; a new start then loads normally.
- reset_n low mid-RUN -> all outputs to reset values asynchronously; no write after release; start ignored while busy (no address relatch).
